// File: rtl/data_memory_ctrl.sv
// Parametrised MEM-stage data memory for the ARM pipeline.
// Synchronous writes, registered reads after WAIT_CYCLES busy cycles, a one-cycle
// ready/err completion pulse, word or byte (LDRB/STRB) access, and out-of-range detection.
module data_memory_ctrl #(
    parameter int          DATA_W      = 32,
    parameter int          DEPTH       = 64,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_W_EN,
    input  logic              MEM_R_EN,
    input  logic              BYTE_EN,
    input  logic [31:0]       ALU_Res,
    input  logic [DATA_W-1:0] Val_Rm,
    output logic [DATA_W-1:0] out,
    output logic              ready,
    output logic              err
);

    localparam int BYTES = DATA_W / 8;
    localparam int B     = $clog2(BYTES);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW    = (B > 0) ? B : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_byte;
    logic              r_inrange;
    logic [AW-1:0]     r_idx;
    logic [LW-1:0]     r_lane;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_req;
    logic [31:0]       w_offset;
    logic [31:0]       w_index;
    logic              w_inrange;
    logic [AW-1:0]     w_idx;
    logic [LW-1:0]     w_lane;

    logic              w_use_live;
    logic              w_enter_done;
    logic              w_c_we;
    logic              w_c_byte;
    logic              w_c_inrange;
    logic [AW-1:0]     w_c_idx;
    logic [LW-1:0]     w_c_lane;
    logic [DATA_W-1:0] w_c_wdata;
    logic [DATA_W-1:0] w_rd_word;
    logic [7:0]        w_rd_byte;
    logic [DATA_W-1:0] w_rd_data;

    assign w_req     = MEM_W_EN | MEM_R_EN;
    assign w_offset  = ALU_Res - BASE_ADDR;
    assign w_index   = w_offset >> B;
    assign w_inrange = (ALU_Res >= BASE_ADDR) && (w_index < 32'(DEPTH));
    assign w_idx     = w_index[AW-1:0];
    assign w_lane    = (B > 0) ? ALU_Res[LW-1:0] : '0;

    // With WAIT_CYCLES = 0 the access completes on its accept edge, so the
    // live request feeds the commit path; otherwise the latched copy does.
    assign w_use_live   = (r_state == S_IDLE);
    assign w_enter_done = rst && (((r_state == S_IDLE) && w_req && (WAIT_CYCLES == 0)) ||
                                  ((r_state == S_BUSY) && (r_cnt == 4'd1)));

    // Select the access attributes that apply on the edge entering DONE
    always_comb begin
        w_c_we      = r_we;
        w_c_byte    = r_byte;
        w_c_inrange = r_inrange;
        w_c_idx     = r_idx;
        w_c_lane    = r_lane;
        w_c_wdata   = r_wdata;
        if (w_use_live) begin
            w_c_we      = MEM_W_EN;
            w_c_byte    = BYTE_EN;
            w_c_inrange = w_inrange;
            w_c_idx     = w_idx;
            w_c_lane    = w_lane;
            w_c_wdata   = Val_Rm;
        end
    end

    // Read data: word, zero-extended byte, or zero when out of range
    always_comb begin
        w_rd_word = r_mem[w_c_idx];
        w_rd_byte = w_rd_word[{w_c_lane, 3'b000} +: 8];
        w_rd_data = '0;
        if (w_c_inrange) begin
            w_rd_data = w_c_byte ? DATA_W'(w_rd_byte) : w_rd_word;
        end
    end

    // Memory array: commit an in-range write on the edge entering DONE (not reset)
    always_ff @(posedge clk) begin
        if (w_enter_done && w_c_we && w_c_inrange) begin
            if (w_c_byte) begin
                r_mem[w_c_idx][{w_c_lane, 3'b000} +: 8] <= w_c_wdata[7:0];
            end else begin
                r_mem[w_c_idx] <= w_c_wdata;
            end
        end
    end

    // Access sequencer with registered out/ready/err
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_we      <= 1'b0;
            r_byte    <= 1'b0;
            r_inrange <= 1'b0;
            r_idx     <= '0;
            r_lane    <= '0;
            r_wdata   <= '0;
            out       <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready <= 1'b0;
                    err   <= 1'b0;
                    if (w_req) begin
                        r_we      <= MEM_W_EN;
                        r_byte    <= BYTE_EN;
                        r_inrange <= w_inrange;
                        r_idx     <= w_idx;
                        r_lane    <= w_lane;
                        r_wdata   <= Val_Rm;
                        r_cnt     <= 4'(WAIT_CYCLES);
                        if (WAIT_CYCLES == 0) begin
                            r_state <= S_DONE;
                            ready   <= 1'b1;
                            err     <= !w_inrange;
                            if (!MEM_W_EN) begin
                                out <= w_rd_data;
                            end
                        end else begin
                            r_state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_DONE;
                        ready   <= 1'b1;
                        err     <= !r_inrange;
                        if (!r_we) begin
                            out <= w_rd_data;
                        end
                    end
                end
                S_DONE: begin
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    ready   <= 1'b0;
                    err     <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for the fast-path throughput check.
module tb_data_memory_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        w_en = 1'b0, r_en = 1'b0, b_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] out;
    logic        ready, err;

    logic        w_en2 = 1'b0, r_en2 = 1'b0, b_en2 = 1'b0;
    logic [31:0] addr2 = '0, wdata2 = '0;
    logic [31:0] out2;
    logic        ready2, err2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_memory_ctrl #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst), .MEM_W_EN(w_en), .MEM_R_EN(r_en), .BYTE_EN(b_en),
        .ALU_Res(addr), .Val_Rm(wdata), .out(out), .ready(ready), .err(err)
    );

    data_memory_ctrl #(
        .DATA_W(32), .DEPTH(64), .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst), .MEM_W_EN(w_en2), .MEM_R_EN(r_en2), .BYTE_EN(b_en2),
        .ALU_Res(addr2), .Val_Rm(wdata2), .out(out2), .ready(ready2), .err(err2)
    );

    // One access on the WAIT_CYCLES=2 instance; lat = rising edges from accept to ready (-1 on timeout)
    task automatic access(input logic we, input logic re, input logic be,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic e, output logic [31:0] o);
        bit seen;
        @(negedge clk);
        w_en = we; r_en = re; b_en = be; addr = a; wdata = d;
        lat = 0; e = 1'bx; o = 'x; seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (ready) begin
                e = err; o = out; seen = 1'b1;
                break;
            end
        end
        if (!seen) lat = -1;
        w_en = 1'b0; r_en = 1'b0; b_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out !== 32'h0)   begin n_fail++; $display("FAIL reset_out: got %h expected %h", out, 32'h0); end
        n_checks++; if (ready !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (ready2 !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b expected 0", ready2); end
        n_checks++; if (out2 !== 32'h0)  begin n_fail++; $display("FAIL reset_out0: got %h expected %h", out2, 32'h0); end
        rst = 1'b1;
    endtask

    task automatic test_word();
        int lat; logic e; logic [31:0] o;
        access(1'b1, 1'b0, 1'b0, 32'd1024, 32'hDEADBEEF, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL word_wr_lat: got %0d expected 3", lat); end
        n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL word_wr_err: got %b expected 0", e); end
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL word_rd_lat: got %0d expected 3", lat); end
        n_checks++; if (o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_rd_data: got %h expected %h", o, 32'hDEADBEEF); end
        n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL word_rd_err: got %b expected 0", e); end
    endtask

    task automatic test_byte();
        int lat; logic e; logic [31:0] o;
        access(1'b1, 1'b0, 1'b0, 32'd1028, 32'h11223344, lat, e, o);
        access(1'b1, 1'b0, 1'b1, 32'd1029, 32'hFFFFFFAA, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL byte_wr_lat: got %0d expected 3", lat); end
        access(1'b0, 1'b1, 1'b1, 32'd1029, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h000000AA) begin n_fail++; $display("FAIL byte_rd_data: got %h expected %h", o, 32'h000000AA); end
        access(1'b0, 1'b1, 1'b1, 32'd1030, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h00000022) begin n_fail++; $display("FAIL byte_rd_lane2: got %h expected %h", o, 32'h00000022); end
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h1122AA44) begin n_fail++; $display("FAIL byte_word_rd: got %h expected %h", o, 32'h1122AA44); end
    endtask

    task automatic test_out_of_range();
        int lat; logic e; logic [31:0] o;
        access(1'b0, 1'b1, 1'b0, 32'd1020, 32'h0, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL oor_rd_lat: got %0d expected 3", lat); end
        n_checks++; if (e !== 1'b1)  begin n_fail++; $display("FAIL oor_rd_err: got %b expected 1", e); end
        n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h expected %h", o, 32'h0); end
        access(1'b1, 1'b0, 1'b0, 32'd1276, 32'h0BADF00D, lat, e, o);
        n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL last_wr_err: got %b expected 0", e); end
        access(1'b1, 1'b0, 1'b0, 32'd1280, 32'hCAFEF00D, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL oor_wr_lat: got %0d expected 3", lat); end
        n_checks++; if (e !== 1'b1)  begin n_fail++; $display("FAIL oor_wr_err: got %b expected 1", e); end
        access(1'b0, 1'b1, 1'b0, 32'd1276, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h0BADF00D) begin n_fail++; $display("FAIL oor_adjacent: got %h expected %h", o, 32'h0BADF00D); end
        n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL oor_adjacent_err: got %b expected 0", e); end
        access(1'b0, 1'b1, 1'b0, 32'd1024, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'hDEADBEEF) begin n_fail++; $display("FAIL oor_word0: got %h expected %h", o, 32'hDEADBEEF); end
    endtask

    task automatic test_both();
        int lat; logic e; logic [31:0] o;
        access(1'b0, 1'b1, 1'b0, 32'd1028, 32'h0, lat, e, o);
        access(1'b1, 1'b1, 1'b0, 32'd1032, 32'h00000005, lat, e, o);
        n_checks++; if (lat !== 3)   begin n_fail++; $display("FAIL both_lat: got %0d expected 3", lat); end
        n_checks++; if (e !== 1'b0)  begin n_fail++; $display("FAIL both_err: got %b expected 0", e); end
        n_checks++; if (out !== 32'h1122AA44) begin n_fail++; $display("FAIL both_out_held: got %h expected %h", out, 32'h1122AA44); end
        access(1'b0, 1'b1, 1'b0, 32'd1032, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h00000005) begin n_fail++; $display("FAIL both_mem: got %h expected %h", o, 32'h5); end
    endtask

    task automatic test_reset_busy();
        int lat; logic e; logic [31:0] o;
        int pulses;
        access(1'b1, 1'b0, 1'b0, 32'd1036, 32'h12345678, lat, e, o);
        @(negedge clk);
        w_en = 1'b1; addr = 32'd1036; wdata = 32'h00000077;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rb_busy_ready: got %b expected 0", ready); end
        rst = 1'b0; w_en = 1'b0;
        #1;
        n_checks++; if (out !== 32'h0) begin n_fail++; $display("FAIL rb_out_zero: got %h expected %h", out, 32'h0); end
        pulses = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rb_no_ready: got %0d pulses expected 0", pulses); end
        access(1'b0, 1'b1, 1'b0, 32'd1036, 32'h0, lat, e, o);
        n_checks++; if (o !== 32'h12345678) begin n_fail++; $display("FAIL rb_old_value: got %h expected %h", o, 32'h12345678); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic exp_r;
        pulses = 0;
        @(negedge clk);
        w_en2 = 1'b1; addr2 = 32'd1024; wdata2 = 32'hA5A5A5A5;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            exp_r = ((i % 2) == 0);
            if (ready2) pulses++;
            n_checks++; if (ready2 !== exp_r) begin n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected %b", i, ready2, exp_r); end
        end
        w_en2 = 1'b0;
        n_checks++; if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        r_en2 = 1'b1; b_en2 = 1'b1; addr2 = 32'd1026;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (ready2 !== 1'b1) begin n_fail++; $display("FAIL w0_rd_ready: got %b expected 1", ready2); end
        n_checks++; if (out2 !== 32'h000000A5) begin n_fail++; $display("FAIL w0_rd_data: got %h expected %h", out2, 32'hA5); end
        n_checks++; if (err2 !== 1'b0) begin n_fail++; $display("FAIL w0_rd_err: got %b expected 0", err2); end
        r_en2 = 1'b0; b_en2 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_out_of_range();
        test_both();
        test_reset_busy();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised, clocked data memory for the MEM stage of the ARM pipeline.
- Generalises the current word-only data memory in four ways:
  - configurable width, depth and base address;
  - synchronous writes;
  - registered reads with programmable wait states, plus a ready handshake the hazard/freeze logic uses to stall the pipeline;
  - byte (LDRB/STRB) access, with out-of-range detection.

Parameters:
- DATA_W, 32, data word width in bits; a multiple of 8, power of two.
- DEPTH, 64, number of words; a power of two.
- BASE_ADDR, 1024, byte address that maps to word 0.
- WAIT_CYCLES, 2, extra BUSY cycles per access, 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- MEM_W_EN  in  1  write request, held by the pipeline until ready.
- MEM_R_EN  in  1  read request, held by the pipeline until ready.
- BYTE_EN  in  1  1 = byte access, 0 = full-word access.
- ALU_Res  in  32  byte address.
- Val_Rm  in  DATA_W  store data; a byte store uses bits [7:0].
- out  out  DATA_W  read data, held until the next completed read.
- ready  out  1  one-cycle pulse marking completion of the accepted access.
- err  out  1  one-cycle pulse together with ready when the address was out of range.

Behaviour:
- Word-address decoding:
  - B = log2(DATA_W/8).
  - Word index = (ALU_Res - BASE_ADDR) >> B.
  - Byte lane = ALU_Res[B-1:0].
  - In range iff ALU_Res >= BASE_ADDR and index < DEPTH; 32-bit unsigned compare, no wrap.
- Word access ignores the low B address bits; they are not checked for alignment.
- State machine: IDLE, BUSY, DONE.
  - IDLE: if MEM_W_EN or MEM_R_EN, latch address, Val_Rm, BYTE_EN and op.
    - Load the counter with WAIT_CYCLES.
    - Go to BUSY, or straight to DONE if WAIT_CYCLES = 0.
  - BUSY: decrement the counter; at count 1, go to DONE.
  - DONE: ready = 1 (err = 1 if out of range) for exactly this cycle, then IDLE.
  - A request held high re-arms on the IDLE cycle after DONE. The pipeline drops or changes the request on the DONE edge as it advances.
- Latency from the accept edge to ready high: WAIT_CYCLES + 1 cycles. Back-to-back throughput is one access per WAIT_CYCLES + 2 cycles.
- The pipeline computes freeze = (MEM_R_EN | MEM_W_EN) & ~ready.
- Inputs sampled in BUSY or DONE are ignored; the latched values rule.
- Simultaneous MEM_W_EN and MEM_R_EN: treated as a write; out unchanged; no error.
- Write commit happens on the edge entering DONE, and only if in range:
  - Word: the whole word.
  - Byte: only lane (byte lane index) takes Val_Rm[7:0]; the other lanes are kept.
- Read result is registered into out on the edge entering DONE:
  - Word: mem[index].
  - Byte: the selected byte, zero-extended.
  - Out of range: out = 0.
- Out-of-range write: memory untouched; err pulses.
- Reset (rst = 0, asynchronous):
  - State IDLE, counter 0, out 0, ready 0, err 0.
  - Memory contents are not reset.
  - Reset during BUSY aborts the access: no write occurs, out stays 0.
- ready and err are registered outputs; they are never high outside DONE.

Test Plan:
- Reset, WAIT_CYCLES = 2; word write 0xDEADBEEF at 1024, then word read at 1024 -> ready 3 cycles after each accept; out = 0xDEADBEEF; err = 0.
- Word 0x11223344 at 1028; byte write 0xAA at 1029, then byte read at 1029 -> out = 0x000000AA; word read at 1028 -> 0x1122AA44.
- Read at 1020, and write at 1024 + 4*DEPTH -> err and ready pulse together; out = 0; a re-read of the adjacent in-range word is unchanged.
- MEM_W_EN and MEM_R_EN both high, Val_Rm = 0x5, address 1032 -> mem[2] = 5; out keeps its prior value.
- Drive rst low for one cycle mid-BUSY of a write of 0x77 at 1036 -> ready never pulses; later read of 1036 returns the old value; out = 0 after reset.
- WAIT_CYCLES = 0 build; request held for 4 accesses -> ready one cycle after each accept; ready high every second cycle.
